// File: rtl/fetch_pkg.sv
// Shared types and instruction constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/fetch_target_check.sv
// Flags a fetch target that is misaligned or outside instruction memory.
// Purely combinational; no flow control.
module fetch_target_check #(
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic [31:0] next_pc,
  output logic        illegal
);

  // Compare in 33 bits so IMEM_WORDS up to 2^30 does not overflow the limit.
  localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) << 2;

  assign illegal = (next_pc[1:0] != 2'b00) || ({1'b0, next_pc} >= LIMIT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, forwards the fetched word to decode, zero-latency.
// PCStall freezes PC/state/counter; HALT and FAULT are terminal until rst.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCStall,
  input  logic        PCBranchTaken,
  input  logic [31:0] PCBranchTarget,
  input  logic        PCHaltReq,
  input  logic [31:0] FetchInstr,
  output logic [31:0] PCAddress,
  output logic [31:0] PCPlus4,
  output logic        FetchValid,
  output logic [31:0] FetchInstruction,
  output logic        PCHalted,
  output logic        PCFault,
  output logic [31:0] PCFetchCount
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [32:0]  seq_sum;
  logic [31:0]  next_pc;
  logic         seq_wrap;
  logic         target_illegal;

  assign seq_sum  = {1'b0, pc_q} + 33'd4;
  assign PCPlus4  = seq_sum[31:0];
  assign next_pc  = PCBranchTaken ? PCBranchTarget : PCPlus4;
  // Sequential wrap past the top of the address space lands on 0, which looks legal.
  assign seq_wrap = !PCBranchTaken && seq_sum[32];

  fetch_target_check #(
    .IMEM_WORDS(IMEM_WORDS)
  ) u_target_check (
    .next_pc (next_pc),
    .illegal (target_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!PCStall) begin
          cnt_d = cnt_q + 32'd1;
          if (PCHaltReq || (FetchInstr == INSTR_EBREAK)) begin
            state_d = HALT;
          end else if (target_illegal || seq_wrap) begin
            state_d = FAULT;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      default: ;
    endcase
  end

  assign PCAddress        = pc_q;
  assign PCFetchCount     = cnt_q;
  assign FetchValid       = (state_q == RUN);
  assign FetchInstruction = FetchValid ? FetchInstr : INSTR_NOP;
  assign PCHalted         = (state_q == HALT);
  assign PCFault          = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ADDI   = 32'h00a0_0093;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCStall = 1'b0;
  logic        PCBranchTaken = 1'b0;
  logic [31:0] PCBranchTarget = 32'd0;
  logic        PCHaltReq = 1'b0;
  logic [31:0] FetchInstr = ADDI;
  logic [31:0] PCAddress;
  logic [31:0] PCPlus4;
  logic        FetchValid;
  logic [31:0] FetchInstruction;
  logic        PCHalted;
  logic        PCFault;
  logic [31:0] PCFetchCount;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .IMEM_WORDS  (1024)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .PCStall          (PCStall),
    .PCBranchTaken    (PCBranchTaken),
    .PCBranchTarget   (PCBranchTarget),
    .PCHaltReq        (PCHaltReq),
    .FetchInstr       (FetchInstr),
    .PCAddress        (PCAddress),
    .PCPlus4          (PCPlus4),
    .FetchValid       (FetchValid),
    .FetchInstruction (FetchInstruction),
    .PCHalted         (PCHalted),
    .PCFault          (PCFault),
    .PCFetchCount     (PCFetchCount)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the DUT in BOOT at a falling edge with rst released.
  task automatic do_reset();
    rst = 1'b1;
    PCStall = 1'b0; PCBranchTaken = 1'b0; PCBranchTarget = 32'd0;
    PCHaltReq = 1'b0; FetchInstr = ADDI;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset, enter RUN, then consume n instructions sequentially.
  task automatic run_to(input int n);
    do_reset();
    step();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (PCAddress !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h want %h", PCAddress, 32'd0); end
    n_checks++; if (FetchValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", FetchValid); end
    n_checks++; if (FetchInstruction !== NOP) begin n_fail++; $display("FAIL reset_instr got %h want %h", FetchInstruction, NOP); end
    n_checks++; if ({PCHalted, PCFault} !== 2'b00) begin n_fail++; $display("FAIL reset_status got %b want 00", {PCHalted, PCFault}); end
    n_checks++; if (PCFetchCount !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", PCFetchCount); end
    rst = 1'b0;
    // First cycle after release is BOOT: nothing fetched yet.
    n_checks++; if (FetchValid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b want 0", FetchValid); end
    n_checks++; if (PCAddress !== 32'd0) begin n_fail++; $display("FAIL boot_pc got %h want 0", PCAddress); end
  endtask

  task automatic test_sequential();
    step();
    for (int i = 0; i < 4; i++) begin
      FetchInstr = ADDI + 32'(i << 20);
      #1;
      n_checks++; if (PCAddress !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, PCAddress, 32'(4 * i)); end
      n_checks++; if (PCPlus4 !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL seq_plus4[%0d] got %h want %h", i, PCPlus4, 32'(4 * i + 4)); end
      n_checks++; if (PCFetchCount !== 32'(i)) begin n_fail++; $display("FAIL seq_count[%0d] got %0d want %0d", i, PCFetchCount, i); end
      n_checks++; if (FetchValid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got %b want 1", i, FetchValid); end
      n_checks++; if (FetchInstruction !== ADDI + 32'(i << 20)) begin n_fail++; $display("FAIL seq_instr[%0d] got %h want %h", i, FetchInstruction, ADDI + 32'(i << 20)); end
      step();
    end
  endtask

  task automatic test_stall();
    run_to(2);
    PCStall = 1'b1; PCBranchTaken = 1'b1; PCBranchTarget = 32'h40; PCHaltReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (PCAddress !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d] got %h want %h", i, PCAddress, 32'h8); end
      n_checks++; if (PCFetchCount !== 32'd2) begin n_fail++; $display("FAIL stall_count[%0d] got %0d want 2", i, PCFetchCount); end
      n_checks++; if (PCHalted !== 1'b0) begin n_fail++; $display("FAIL stall_halt[%0d] got %b want 0", i, PCHalted); end
    end
    PCStall = 1'b0; PCHaltReq = 1'b0;
    step();
    n_checks++; if (PCAddress !== 32'h40) begin n_fail++; $display("FAIL branch_pc got %h want %h", PCAddress, 32'h40); end
    n_checks++; if (PCFetchCount !== 32'd3) begin n_fail++; $display("FAIL branch_count got %0d want 3", PCFetchCount); end
    PCBranchTaken = 1'b0;
  endtask

  task automatic test_fault_target(input logic [31:0] target);
    run_to(4);
    PCBranchTaken = 1'b1; PCBranchTarget = target;
    step();
    PCBranchTaken = 1'b0;
    n_checks++; if (PCFault !== 1'b1) begin n_fail++; $display("FAIL fault_flag[%h] got %b want 1", target, PCFault); end
    n_checks++; if (PCAddress !== 32'h10) begin n_fail++; $display("FAIL fault_pc[%h] got %h want %h", target, PCAddress, 32'h10); end
    n_checks++; if (PCFetchCount !== 32'd5) begin n_fail++; $display("FAIL fault_count[%h] got %0d want 5", target, PCFetchCount); end
    n_checks++; if (FetchValid !== 1'b0) begin n_fail++; $display("FAIL fault_valid[%h] got %b want 0", target, FetchValid); end
    n_checks++; if (FetchInstruction !== NOP) begin n_fail++; $display("FAIL fault_instr[%h] got %h want %h", target, FetchInstruction, NOP); end
    step(); step();
    n_checks++; if (PCAddress !== 32'h10 || PCFault !== 1'b1) begin n_fail++; $display("FAIL fault_sticky[%h] got pc %h fault %b want pc 10 fault 1", target, PCAddress, PCFault); end
  endtask

  task automatic test_seq_end();
    run_to(1023);
    n_checks++; if (PCAddress !== 32'hFFC) begin n_fail++; $display("FAIL end_pc got %h want %h", PCAddress, 32'hFFC); end
    n_checks++; if (PCFault !== 1'b0) begin n_fail++; $display("FAIL end_nofault got %b want 0", PCFault); end
    step();
    n_checks++; if (PCFault !== 1'b1) begin n_fail++; $display("FAIL end_fault got %b want 1", PCFault); end
    n_checks++; if (PCAddress !== 32'hFFC) begin n_fail++; $display("FAIL end_frozen got %h want %h", PCAddress, 32'hFFC); end
    n_checks++; if (PCFetchCount !== 32'd1024) begin n_fail++; $display("FAIL end_count got %0d want 1024", PCFetchCount); end
  endtask

  task automatic test_ebreak();
    run_to(8);
    FetchInstr = EBREAK;
    step();
    FetchInstr = ADDI;
    n_checks++; if (PCHalted !== 1'b1) begin n_fail++; $display("FAIL ebreak_halt got %b want 1", PCHalted); end
    n_checks++; if (PCAddress !== 32'h20) begin n_fail++; $display("FAIL ebreak_pc got %h want %h", PCAddress, 32'h20); end
    n_checks++; if (PCFetchCount !== 32'd9) begin n_fail++; $display("FAIL ebreak_count got %0d want 9", PCFetchCount); end
    n_checks++; if (FetchValid !== 1'b0) begin n_fail++; $display("FAIL ebreak_valid got %b want 0", FetchValid); end
    PCHaltReq = 1'b1; PCBranchTaken = 1'b1; PCBranchTarget = 32'h40;
    step(); step();
    PCHaltReq = 1'b0; PCBranchTaken = 1'b0;
    n_checks++; if (PCAddress !== 32'h20 || PCFetchCount !== 32'd9) begin n_fail++; $display("FAIL halt_frozen got pc %h count %0d want pc 20 count 9", PCAddress, PCFetchCount); end
    n_checks++; if (PCHalted !== 1'b1 || PCFault !== 1'b0) begin n_fail++; $display("FAIL halt_terminal got halt %b fault %b want 1 0", PCHalted, PCFault); end
  endtask

  // Halt request outranks a simultaneous branch.
  task automatic test_halt_req();
    run_to(1);
    PCHaltReq = 1'b1; PCBranchTaken = 1'b1; PCBranchTarget = 32'h80;
    step();
    PCHaltReq = 1'b0; PCBranchTaken = 1'b0;
    n_checks++; if (PCHalted !== 1'b1) begin n_fail++; $display("FAIL haltreq_halt got %b want 1", PCHalted); end
    n_checks++; if (PCAddress !== 32'h4) begin n_fail++; $display("FAIL haltreq_pc got %h want %h", PCAddress, 32'h4); end
    n_checks++; if (PCFetchCount !== 32'd2) begin n_fail++; $display("FAIL haltreq_count got %0d want 2", PCFetchCount); end
  endtask

  task automatic test_async_reset();
    run_to(4);
    PCBranchTaken = 1'b1; PCBranchTarget = 32'h22;
    step();
    PCBranchTaken = 1'b0;
    n_checks++; if (PCFault !== 1'b1) begin n_fail++; $display("FAIL arst_pre got %b want 1", PCFault); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (PCFault !== 1'b0) begin n_fail++; $display("FAIL arst_fault got %b want 0", PCFault); end
    n_checks++; if (PCAddress !== 32'd0 || PCFetchCount !== 32'd0) begin n_fail++; $display("FAIL arst_pc got pc %h count %0d want 0 0", PCAddress, PCFetchCount); end
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (FetchValid !== 1'b0) begin n_fail++; $display("FAIL arst_boot got %b want 0", FetchValid); end
    step();
    n_checks++; if (FetchValid !== 1'b1 || PCAddress !== 32'd0) begin n_fail++; $display("FAIL arst_run got valid %b pc %h want 1 0", FetchValid, PCAddress); end
    step();
    n_checks++; if (PCAddress !== 32'h4 || PCFetchCount !== 32'd1) begin n_fail++; $display("FAIL arst_resume got pc %h count %0d want 4 1", PCAddress, PCFetchCount); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_fault_target(32'h22);
    test_fault_target(32'h1000);
    test_seq_end();
    test_ebreak();
    test_halt_req();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction-fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives the memory's word-aligned byte address.
- Receives the fetched word back combinationally and forwards it, with a valid flag, to decode.
- Handles branch/jump redirects, pipeline stalls, halt (external or EBREAK) and illegal fetch targets via a small state machine, and counts fetched instructions.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words; legal byte addresses are 0 .. IMEM_WORDS*4-4.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCStall  in  1  hold PC and state this cycle.
- PCBranchTaken  in  1  redirect to PCBranchTarget at next edge.
- PCBranchTarget  in  32  byte address of redirect.
- PCHaltReq  in  1  request halt.
- FetchInstr  in  32  word returned by instruction memory for PCAddress (same cycle).
- PCAddress  out  32  current PC, drives memory address.
- PCPlus4  out  32  PCAddress+4, mod 2^32.
- FetchValid  out  1  FetchInstruction is a real instruction.
- FetchInstruction  out  32  FetchInstr when valid, else NOP 32'h0000_0013.
- PCHalted  out  1  state is HALT.
- PCFault  out  1  state is FAULT (sticky until reset).
- PCFetchCount  out  32  instructions consumed since reset.

## Operation
- States: BOOT, RUN, HALT, FAULT.
- Reset: state=BOOT, PC=RESET_VECTOR, PCFetchCount=0. Outputs: FetchValid=0, PCHalted=0, PCFault=0, FetchInstruction=NOP.
- BOOT → RUN unconditionally at the first edge after reset release. No fetch is consumed in BOOT.
- FetchValid = (state==RUN). An instruction is consumed when FetchValid && !PCStall.
- RUN, priority highest first:
  - PCStall=1: PC, state and counter hold; branch and halt inputs are ignored.
  - PCHaltReq=1 or FetchInstr==EBREAK (32'h0010_0073): counter+1, PC holds, → HALT.
  - Otherwise the next PC is PCBranchTaken ? PCBranchTarget : PCPlus4.
    - Next PC illegal (bits[1:0]≠0, or ≥ IMEM_WORDS*4, including wrap past 32'hFFFF_FFFC): counter+1, PC holds, → FAULT.
    - Next PC legal: counter+1, PC ← next PC.
- HALT and FAULT are terminal; only rst leaves them. PC frozen, FetchValid=0, all inputs ignored.
- Counter wraps 32'hFFFF_FFFF → 0.
- RESET_VECTOR itself is not checked. An illegal RESET_VECTOR is a configuration error.

## Timing
- PCAddress, PCPlus4 and status outputs are register-driven (PCPlus4 via adder from PC register). No input-to-PCAddress combinational path.
- FetchInstruction/FetchValid are combinational from FetchInstr and state, for zero-latency fetch in the single-cycle datapath.
- Redirect latency: PCBranchTaken sampled at edge N, PCAddress = target after edge N.
- Halt/fault visible on PCHalted/PCFault one cycle after the triggering edge.
- rst asserted mid-run forces reset values immediately (asynchronous), regardless of state.

## Structure
- Package fetch_pkg holds:
  - fetch_state_t enum {BOOT, RUN, HALT, FAULT};
  - INSTR_NOP = 32'h0000_0013;
  - INSTR_EBREAK = 32'h0010_0073.
- One combinational sub-module, fetch_target_check: inputs next PC and IMEM_WORDS, output illegal flag.
- FSM, PC register and counter live in fetch_unit.

## Test plan
- Reset release, no stimulus → cycle 1 FetchValid=0, PCAddress=0; then PCAddress 0,4,8,12 on successive cycles, PCFetchCount 0,1,2,3.
- In RUN at PC=8: PCStall=1 for 3 cycles with PCBranchTaken=1, target 0x40 → PC stays 8, count unchanged. Drop stall with branch held → PC=0x40 next cycle.
- At PC=0x10: branch to 0x22 → PCFault=1 next cycle, PC stays 0x10, FetchValid=0 thereafter; branch to 0x1000 with IMEM_WORDS=1024 → same.
- Sequential run reaching PC=0xFFC (IMEM_WORDS=1024) → FAULT, PC frozen at 0xFFC.
- FetchInstr=32'h0010_0073 at PC=0x20 → PCHalted=1 next cycle, PC=0x20, count incremented once. A later PCHaltReq or branch has no effect.
- Assert rst asynchronously mid-cycle while in FAULT → PCFault=0, PCAddress=RESET_VECTOR before next edge; BOOT then RUN resumes.
